// File: rtl/matdet_sched_if.sv
// Requester and response channels of matdet_sched.
// master: requester fabric side; slave: scheduler side.
interface matdet_sched_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MATRIX_SIZE = 3,
    parameter int unsigned NUM_REQ     = 4
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned MAT_W = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*MAT_W-1:0]   req_matrix;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [DATA_WIDTH-1:0]      rsp_det;
    logic [ID_W-1:0]            rsp_id;

    modport master (
        output req_valid, req_matrix, rsp_ready,
        input  req_ready, rsp_valid, rsp_det, rsp_id
    );

    modport slave (
        input  req_valid, req_matrix, rsp_ready,
        output req_ready, rsp_valid, rsp_det, rsp_id
    );
endinterface

// File: rtl/matdet_sched.sv
// Round-robin scheduler sharing one matdet<N> datapath across NUM_REQ requesters.
// Define SCHED_PIPE_EN to give the datapath a 2-cycle evaluation window.
module matdet_sched #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MATRIX_SIZE = 3,
    parameter int unsigned NUM_REQ     = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    matdet_sched_if.slave                                bus,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] dp_matrix,
    input  logic [DATA_WIDTH-1:0]                        dp_det,
    output logic                                         busy
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned MAT_W = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;

`ifdef SCHED_PIPE_EN
    typedef enum logic [1:0] {S_IDLE, S_EVAL0, S_EVAL1, S_RESP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;
`endif

    state_t                 state_q;
    state_t                 state_nx;
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        id_q;
    logic [DATA_WIDTH-1:0]  rsp_det_q;
    logic [ID_W-1:0]        rsp_id_q;
    logic                   rsp_valid_q;
    logic                   busy_q;

    logic                   gnt_found;
    logic [ID_W-1:0]        gnt_idx;
    logic [ID_W-1:0]        ptr_inc;
    logic [MAT_W-1:0]       gnt_matrix;
    logic [NUM_REQ-1:0]     req_ready_c;
    logic                   grant_fire;
    logic                   capture;
    logic [ID_W-1:0]        cand;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin : rr_pick
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin : gnt_mux
        gnt_matrix = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (gnt_idx == ID_W'(r)) begin
                gnt_matrix = bus.req_matrix[r*MAT_W +: MAT_W];
            end
        end
    end

    assign ptr_inc = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    // Next-state and strobes; ready is gated by rst_n so nothing is offered while in reset.
    always_comb begin : fsm_next
        state_nx    = state_q;
        req_ready_c = '0;
        grant_fire  = 1'b0;
        capture     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found && rst_n) begin
                    req_ready_c[gnt_idx] = 1'b1;
                    grant_fire           = 1'b1;
`ifdef SCHED_PIPE_EN
                    state_nx             = S_EVAL0;
`else
                    state_nx             = S_EVAL;
`endif
                end
            end
`ifdef SCHED_PIPE_EN
            S_EVAL0: begin
                state_nx = S_EVAL1;
            end
            S_EVAL1: begin
                capture  = 1'b1;
                state_nx = S_RESP;
            end
`else
            S_EVAL: begin
                capture  = 1'b1;
                state_nx = S_RESP;
            end
`endif
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nx;
            busy_q      <= (state_nx != S_IDLE);
            rsp_valid_q <= (state_nx == S_RESP);
        end
    end

    // Datapath operand, owner tracking and response capture.
    always_ff @(posedge clk or negedge rst_n) begin : dp_reg
        if (!rst_n) begin
            dp_matrix <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            rsp_det_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            if (grant_fire) begin
                dp_matrix <= gnt_matrix;
                id_q      <= gnt_idx;
                ptr_q     <= ptr_inc;
            end
            if (capture) begin
                rsp_det_q <= dp_det;
                rsp_id_q  <= id_q;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_det   = rsp_det_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_matdet_sched.sv
// Directed bench for matdet_sched with a behavioural matdet2 on the dp_* ports.
// Expected values are hand-computed 2x2 determinants modulo 256.
module tb_matdet_sched;
    localparam int unsigned DW = 8;
    localparam int unsigned MS = 2;
    localparam int unsigned NR = 4;
`ifdef SCHED_PIPE_EN
    localparam int EVAL_CYC = 2;
`else
    localparam int EVAL_CYC = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] dp_matrix;
    logic [7:0]  dp_det;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    matdet_sched_if #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .NUM_REQ(NR)) bus ();

    matdet_sched #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .NUM_REQ(NR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dp_matrix(dp_matrix),
        .dp_det   (dp_det),
        .busy     (busy)
    );

    // matdet2: a*d - b*c, row-major elements a,b,c,d at bytes 0..3
    assign dp_det = dp_matrix[7:0] * dp_matrix[31:24] - dp_matrix[15:8] * dp_matrix[23:16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] mat(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    task automatic set_slot(input int r, input logic [31:0] m);
        bus.req_matrix[r*32 +: 32] = m;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0]  exp_det [4];
    logic [31:0] m_a;

    initial begin
        int n;
        int prev;
        exp_det[0] = 8'hfe;
        exp_det[1] = 8'h06;
        exp_det[2] = 8'h18;
        exp_det[3] = 8'hf6;

        rst_n          = 1'b1;
        bus.req_valid  = '0;
        bus.req_matrix = '0;
        bus.rsp_ready  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_det", 32'(bus.rsp_det), 32'h0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_dp_matrix", dp_matrix, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // single request from requester 2
        m_a = mat(8'd3, 8'd1, 8'd2, 8'd4);
        set_slot(2, m_a);
        bus.req_valid = 4'b0100;
        #1;
        check("s1_ready", 32'(bus.req_ready), 32'h4);
        check("s1_busy_idle", 32'(busy), 32'h0);
        tick();
        bus.req_valid = '0;
        #1;
        check("s1_ready_off", 32'(bus.req_ready), 32'h0);
        check("s1_busy_eval", 32'(busy), 32'h1);
        check("s1_dp_matrix", dp_matrix, m_a);
        for (int i = 0; i < EVAL_CYC; i++) begin
            check("s1_no_rsp_early", 32'(bus.rsp_valid), 32'h0);
            tick();
        end
        check("s1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("s1_rsp_det", 32'(bus.rsp_det), 32'h0a);
        check("s1_rsp_id", 32'(bus.rsp_id), 32'h2);
        tick();
        check("s1_busy_done", 32'(busy), 32'h0);
        check("s1_rsp_done", 32'(bus.rsp_valid), 32'h0);
        check("s1_dp_hold", dp_matrix, m_a);

        // pointer sits at 3 after granting 2; an idle period must not move it
        tick();
        tick();
        bus.req_valid = 4'b1010;
        #1;
        check("rr_from_ptr", 32'(bus.req_ready), 32'h8);
        bus.req_valid = '0;
        #1;
        check("rr_drop_no_ready", 32'(bus.req_ready), 32'h0);

        // all four valid continuously from a fresh pointer
        pulse_reset();
        set_slot(0, mat(8'd1, 8'd2, 8'd3, 8'd4));
        set_slot(1, mat(8'd2, 8'd0, 8'd0, 8'd3));
        set_slot(2, mat(8'd5, 8'd1, 8'd1, 8'd5));
        set_slot(3, mat(8'd2, 8'd3, 8'd4, 8'd1));
        bus.req_valid = 4'b1111;
        #1;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!bus.rsp_valid && n < 20) begin
                tick();
                n++;
            end
            check("stream_rsp_seen", 32'(bus.rsp_valid), 32'h1);
            check("stream_rsp_id", 32'(bus.rsp_id), 32'(k % 4));
            check("stream_rsp_det", 32'(bus.rsp_det), 32'(exp_det[k % 4]));
            if (k > 0) begin
                check("stream_interval", 32'(cyc - prev), 32'(2 + EVAL_CYC));
            end
            prev = cyc;
            if (k == 5) begin
                bus.req_valid = '0;
            end
            tick();
        end

        // backpressure: requester 3 response held while requester 1 waits
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1000;
        #1;
        check("bp_ready_r3", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = 4'b0010;
        #1;
        check("bp_eval_ready", 32'(bus.req_ready), 32'h0);
        for (int i = 0; i < EVAL_CYC; i++) begin
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            check("bp_rsp_det", 32'(bus.rsp_det), 32'hf6);
            check("bp_rsp_id", 32'(bus.rsp_id), 32'h3);
            check("bp_req_ready", 32'(bus.req_ready), 32'h0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_rsp_still", 32'(bus.rsp_valid), 32'h1);
        tick();
        check("bp_regrant", 32'(bus.req_ready), 32'h2);
        check("bp_idle_busy", 32'(busy), 32'h0);
        tick();
        bus.req_valid = '0;
        for (int i = 0; i < EVAL_CYC; i++) begin
            tick();
        end
        check("bp_r1_valid", 32'(bus.rsp_valid), 32'h1);
        check("bp_r1_id", 32'(bus.rsp_id), 32'h1);
        check("bp_r1_det", 32'(bus.rsp_det), 32'h06);
        tick();

        // reset during EVAL discards the in-flight request and rewinds the pointer
        bus.req_valid = 4'b1111;
        #1;
        check("rst_pre_grant", 32'(bus.req_ready), 32'h4);
        tick();
        rst_n = 1'b0;
        #1;
        check("rstm_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rstm_busy", 32'(busy), 32'h0);
        check("rstm_dp_matrix", dp_matrix, 32'h0);
        check("rstm_req_ready", 32'(bus.req_ready), 32'h0);
        check("rstm_rsp_det", 32'(bus.rsp_det), 32'h0);
        check("rstm_rsp_id", 32'(bus.rsp_id), 32'h0);
        tick();
        check("rstm_no_rsp", 32'(bus.rsp_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rstm_ptr_zero", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        for (int i = 0; i < EVAL_CYC; i++) begin
            tick();
        end
        check("rstm_r0_valid", 32'(bus.rsp_valid), 32'h1);
        check("rstm_r0_id", 32'(bus.rsp_id), 32'h0);
        check("rstm_r0_det", 32'(bus.rsp_det), 32'hfe);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/matdet_sched.md
# matdet_sched

Round-robin scheduler that shares one combinational `matdet<N>` determinant datapath between `NUM_REQ` requesters. Each requester offers a packed matrix with a valid/ready handshake. The scheduler registers the granted matrix onto the datapath input, waits the configured evaluation time, and captures the determinant. It then returns the result with the requester's ID over a single valid/ready response channel. It sits between the requester fabric and the `matdet<N>` instance, which is instantiated by the parent and connected through the `dp_*` ports.

## Interface
- `DATA_WIDTH`, 32, element and determinant width in bits.
- `MATRIX_SIZE`, 3, matrix dimension N. Must match the attached `matdet<N>`.
- `NUM_REQ`, 4, number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`, width of the requester ID. Derived; do not override.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, NUM_REQ: per-requester request valid.
- `req_ready`, output, NUM_REQ: per-requester grant. One-hot or zero.
- `req_matrix`, input, NUM_REQ·N²·DATA_WIDTH: requester r's matrix at slice `[r*N²*W +: N²*W]`. Element i is at `[i*W +: W]`, row-major.
- `dp_matrix`, output, N²·DATA_WIDTH: registered matrix driven into `matdet<N>`.
- `dp_det`, input, DATA_WIDTH: determinant from `matdet<N>`.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: response accept.
- `rsp_det`, output, DATA_WIDTH: captured determinant.
- `rsp_id`, output, ID_W: index of the requester that owns the response.
- `busy`, output, 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE → EVAL → RESP → IDLE.
- When `SCHED_PIPE_EN` is defined, EVAL is split into EVAL0 and EVAL1.
- IDLE, grant:
  - Round-robin over `req_valid`, starting at pointer `ptr`.
  - Grant is the first set bit at or after `ptr`, wrapping modulo NUM_REQ.
  - `req_ready[g]` is combinational, asserted only in IDLE. All other ready bits are 0.
  - On a handshake edge:
    - `dp_matrix` ← that requester's slice.
    - `id_q` ← g.
    - `ptr` ← (g+1) mod NUM_REQ.
    - Next state is EVAL.
  - With no valid request, stay in IDLE and leave `ptr` unchanged.
- EVAL: hold `dp_matrix`. On the last EVAL cycle, `rsp_det` ← `dp_det`, `rsp_id` ← `id_q`, and next state is RESP.
- RESP:
  - `rsp_valid`=1 with `rsp_det`/`rsp_id` stable until `rsp_ready`.
  - On the handshake edge, next state is IDLE.
  - No new grant is made in the handshake cycle.
- `dp_matrix` keeps the last granted matrix until the next grant. It is never cleared except by reset.
- Arithmetic: the determinant is passed through unchanged. Wrap modulo 2^DATA_WIDTH is the datapath's behaviour; the scheduler adds nothing.
- Requesters must hold `req_valid` and `req_matrix` until ready. If a requester drops valid before it is granted, it is simply not granted, and the request is not remembered.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_det`=0, `rsp_id`=0, `busy`=0.
  - `dp_matrix`=0, `ptr`=0, state IDLE.
- Latency, grant edge to `rsp_valid` high: 2 cycles; 3 cycles with `SCHED_PIPE_EN`.
- Minimum issue interval, with `rsp_ready` tied high: 3 cycles; 4 cycles with `SCHED_PIPE_EN`.
- All requesters valid: grants in order 0,1,…,NUM_REQ-1,0 with no starvation.
- A request held during RESP backpressure waits in IDLE. It is granted on the first IDLE cycle after the response handshake.
- Reset asserted mid-operation: immediate return to reset values. An in-flight response is discarded and `ptr` returns to 0.
- Reset deassertion does not create a grant until the first clock edge with `rst_n`=1.

## Configuration
- `SCHED_PIPE_EN` defined: two EVAL cycles (EVAL0, EVAL1). `dp_det` is sampled at the end of EVAL1, which allows a 2-cycle multicycle path through `matdet<N>` for large N or wide DATA_WIDTH.
- `SCHED_PIPE_EN` not defined: a single EVAL cycle, and `matdet<N>` must close timing in one cycle.

## Test plan
Configuration for all scenarios: DATA_WIDTH=8, MATRIX_SIZE=2, NUM_REQ=4, `matdet2` attached, unless a line says otherwise.

- Single request: requester 2 sends [3,1,2,4] with `rsp_ready`=1.
  - `req_ready`=4'b0100 for one cycle.
  - `rsp_valid` 2 cycles later with `rsp_det`=8'h0a and `rsp_id`=2.
  - `busy` low again 1 cycle after that.
- All four valid continuously, each with a distinct matrix: responses arrive with `rsp_id` sequence 0,1,2,3,0,1, each `rsp_det` correct, and one response every 3 cycles.
- Backpressure: `rsp_ready`=0 for 5 cycles during RESP while requester 1 is valid.
  - `rsp_valid`, `rsp_det` and `rsp_id` are stable for all 5 cycles.
  - `req_ready` stays 0.
  - Requester 1 is granted in the first IDLE cycle after the handshake.
- Wrap: [2,3,4,1] gives det = 2−12 = −10, so `rsp_det`=8'hf6.
- Reset mid-EVAL: pull `rst_n` low for 1 cycle during EVAL. All outputs return to 0, no response appears, and the next grant with all valid goes to requester 0.
- `SCHED_PIPE_EN` build: repeat the first scenario. `rsp_valid` now rises 3 cycles after the grant, with `rsp_det`=8'h0a.
